// File: rtl/seq_mul_shift_add_if.sv
// Handshake bundle for the sequential shift-add multiplier: request side
// (start/mode/operands) and result side (busy/done/prod).
interface seq_mul_shift_add_if #(
  parameter int WIDTH = 8
);
  logic                 start;
  logic                 signed_mode;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   prod;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, prod
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, prod
  );
endinterface

// File: rtl/seq_mul_shift_add.sv
// Sequential shift-add multiplier: one partial product per clock, signed or unsigned.
// Optional macro SEQ_MUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier is zero.
module seq_mul_shift_add #(
  parameter int WIDTH = 8
) (
  input logic               clk,
  input logic               rst,
  seq_mul_shift_add_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [PW-1:0]     prod_q, prod_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [CW-1:0]     count_q, count_d;
  logic              neg_q, neg_d;

  logic              accept;
  logic              lastCycle;
  logic [PW-1:0]     accSum;
  logic [WIDTH-1:0]  magA, magB;
  logic              negIn;

  assign accept = bus.start && (state_q != RUN);
  assign accSum = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Signed operands are reduced to magnitudes; the most-negative value still fits unsigned.
  assign magA  = (bus.signed_mode && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign magB  = (bus.signed_mode && bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign negIn = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);

`ifdef SEQ_MUL_EARLY_TERM_EN
  assign lastCycle = (count_q == CW'(WIDTH - 1)) || (mplier_q[WIDTH-1:1] == '0);
`else
  assign lastCycle = (count_q == CW'(WIDTH - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (lastCycle) state_d = DONE;
      DONE:    state_d = bus.start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    neg_d    = neg_q;
    prod_d   = prod_q;
    if (accept) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, magA};
      mplier_d = magB;
      count_d  = '0;
      neg_d    = negIn;
    end else if (state_q == RUN) begin
      acc_d    = accSum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CW'(1);
      // The final sum is taken straight from the adder so prod lands with done.
      if (lastCycle) begin
        prod_d = neg_q ? -accSum : accSum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
      prod_q   <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
      prod_q   <= prod_d;
    end
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.prod = prod_q;
  end
endmodule
